// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential restoring divider.
// Holds the FSM encoding and the default widths shared with the multiplier.
package seq_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int M_DEF = 8;
    localparam int N_DEF = 4;

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational restoring-division step.
// Ports: prem (n+1) partial remainder, div (n) divisor, bin incoming
// dividend bit; rem (n+1) next partial remainder, qbit quotient bit.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int n = N_DEF
) (
    input  logic [n:0]   prem,
    input  logic [n-1:0] div,
    input  logic         bin,
    output logic [n:0]   rem,
    output logic         qbit
);

    logic [n+1:0] sh;
    logic [n+1:0] dv;

    // Keep the full shifted value so the compare sees every bit; the
    // stored remainder is always below 2^(n+1), so truncation is exact.
    always_comb begin
        sh   = {prem, bin};
        dv   = {2'b00, div};
        qbit = (sh >= dv);
        rem  = qbit ? (n+1)'(sh - dv) : sh[n:0];
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: sequential shift-subtract unsigned divider, one bit/clock.
// Ports: clk, rst (async active-low), start, A (m), B (n) in;
// Q (m), R (n), busy, done out; dz out when DIV_ZERO_FLAG_EN is defined.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int m = M_DEF,
    parameter int n = N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [m-1:0] A,
    input  logic [n-1:0] B,
    output logic [m-1:0] Q,
    output logic [n-1:0] R,
    output logic         busy,
    output logic         done
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic         dz
`endif
);

    localparam int CW = $clog2(m + 1);

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [m-1:0]  areg;
    logic [n-1:0]  breg;
    logic [n:0]    prem;
    logic [n:0]    rem_n;
    logic          qbit;
    logic          last;

    assign last = (cnt == CW'(1));

    // areg shifts dividend bits out of the MSB and quotient bits
    // into the LSB, so after m steps it holds the quotient.
    div_step #(.n(n)) u_step (
        .prem (prem),
        .div  (breg),
        .bin  (areg[m-1]),
        .rem  (rem_n),
        .qbit (qbit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_FLAG_EN
                    state_n = (B == '0) ? DONE : RUN;
`else
                    state_n = RUN;
`endif
                end
            end
            RUN:     if (last) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            areg <= '0;
            breg <= '0;
            prem <= '0;
            Q    <= '0;
            R    <= '0;
`ifdef DIV_ZERO_FLAG_EN
            dz   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        areg <= A;
                        breg <= B;
                        prem <= '0;
                        cnt  <= CW'(m);
`ifdef DIV_ZERO_FLAG_EN
                        dz   <= 1'b0;
                        if (B == '0) begin
                            Q  <= '1;
                            R  <= '0;
                            dz <= 1'b1;
                        end
`endif
                    end
                end
                RUN: begin
                    areg <= {areg[m-2:0], qbit};
                    prem <= rem_n;
                    cnt  <= cnt - CW'(1);
                    if (last) begin
                        Q <= {areg[m-2:0], qbit};
                        R <= rem_n[n-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Testbench for seq_divider: random and directed divides checked
// against an arithmetic reference model.
module tb_seq_divider;

    localparam int M = 8;
    localparam int N = 4;

`ifdef DIV_ZERO_FLAG_EN
    localparam bit DZ = 1'b1;
    logic dz;
`else
    localparam bit DZ = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [M-1:0] A;
    logic [N-1:0] B;
    logic [M-1:0] Q;
    logic [N-1:0] R;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    seq_divider #(.m(M), .n(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Q     (Q),
        .R     (R),
        .busy  (busy),
        .done  (done)
`ifdef DIV_ZERO_FLAG_EN
        ,
        .dz    (dz)
`endif
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d",
                     tag, got, exp);
        end
    endtask

    function automatic int ref_q(input int a, input int b);
        if (b == 0) return (1 << M) - 1;
        return a / b;
    endfunction

    function automatic int ref_r(input int a, input int b);
        if (b == 0) return DZ ? 0 : (a % (1 << N));
        return a % b;
    endfunction

    // One divide with a single-cycle start; operand inputs are
    // scrambled while it runs.
    task automatic do_div(input int a, input int b, input string tag);
        int cyc;
        int bc;
        bit zb;
        zb = DZ && (b == 0);
        @(negedge clk);
        A = M'(a);
        B = N'(b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        bc = int'(busy);
        while (!done && cyc < 40) begin
            A = M'($urandom);
            B = N'($urandom);
            @(negedge clk);
            cyc++;
            bc += int'(busy);
        end
        chk({tag, "_lat"}, cyc, zb ? 1 : M + 1);
        chk({tag, "_busy"}, bc, zb ? 0 : M);
        chk({tag, "_q"}, Q, ref_q(a, b));
        chk({tag, "_r"}, R, ref_r(a, b));
`ifdef DIV_ZERO_FLAG_EN
        chk({tag, "_dz"}, dz, b == 0);
`endif
        @(negedge clk);
        chk({tag, "_pulse"}, done, 0);
    endtask

    initial begin
        int cyc;
        int nd;
        int a;
        int b;
        rst = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        repeat (2) @(negedge clk);
        chk("rst_q", Q, 0);
        chk("rst_r", R, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        #2 rst = 1'b1;

        do_div(225, 15, "rt");
        do_div(100, 0, "dz0");
        do_div(9, 3, "dz_clr");

        // back-to-back with start held high
        @(negedge clk);
        A = 8'd200;
        B = 4'd7;
        start = 1'b1;
        @(negedge clk);
        A = 8'd5;
        B = 4'd9;
        cyc = 1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b1_lat", cyc, M + 1);
        chk("b2b1_q", Q, 28);
        chk("b2b1_r", R, 4);
        @(negedge clk);
        chk("b2b_idle_busy", busy, 0);
        chk("b2b_idle_done", done, 0);
        @(negedge clk);
        chk("b2b_accept", busy, 1);
        A = 8'd24;
        B = 4'd2;
        cyc = 2;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk("b2b2_lat", cyc, M + 2);
        chk("b2b2_q", Q, 0);
        chk("b2b2_r", R, 5);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc < 40);
        chk("b2b3_lat", cyc, M + 2);
        chk("b2b3_q", Q, 12);
        chk("b2b3_r", R, 0);
        start = 1'b0;
        nd = 0;
        repeat (15) begin
            @(negedge clk);
            nd += int'(done);
        end
        chk("b2b_no_extra", nd, 0);

        // start during RUN must be ignored
        @(negedge clk);
        A = 8'd200;
        B = 4'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        A = 8'd99;
        B = 4'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) begin
                nd++;
                chk("ign_q", Q, 28);
                chk("ign_r", R, 4);
            end
        end
        chk("ign_ndone", nd, 1);

        // asynchronous reset mid-divide
        @(negedge clk);
        A = 8'd255;
        B = 4'd15;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mrst_q", Q, 0);
        chk("mrst_r", R, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        @(negedge clk);
        chk("mrst_hold", busy, 0);
        #3 rst = 1'b1;
        do_div(255, 15, "post_rst");

        for (int i = 0; i < 24; i++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 15));
            if (i % 8 == 3) b = 0;
            do_div(a, b, "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
